// File: rtl/sqrt_range_reduce.sv
// Square-root range reduction: leading-one detect and even normalising shift, 3-stage pipeline.
// Define SQRT_RR_ZERO_FLAG_EN to add the pipelined oZero output.
module sqrt_range_reduce #(
  localparam int unsigned W_IN = 24
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic            iEn,
  input  logic            iValid,
  input  logic [W_IN-1:0] iX,
  output logic            oValid,
  output logic [5:0]      oExp_f,
  output logic [21:0]     oX_f
`ifdef SQRT_RR_ZERO_FLAG_EN
  ,
  output logic            oZero
`endif
);

  // Leading-zero count of a 12-bit half; only meaningful when the half is nonzero.
  function automatic logic [3:0] lzc12(input logic [11:0] v);
    lzc12 = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) lzc12 = 4'(11 - i);
    end
  endfunction

  // Stage 1
  logic [W_IN-1:0] x1_q, x1_d;
  logic            v1_q, v1_d;
  logic [3:0]      lzh1_q, lzh1_d, lzl1_q, lzl1_d;
  logic            zh1_q, zh1_d, zl1_q, zl1_d;
  // Stage 2
  logic [W_IN-1:0] x2_q, x2_d;
  logic            v2_q, v2_d;
  logic [4:0]      s2_q, s2_d;
  logic [5:0]      e2_q, e2_d;
  // Stage 3
  logic [21:0]     xf_q, xf_d;
  logic            v3_q, v3_d;
  logic [5:0]      e3_q, e3_d;
`ifdef SQRT_RR_ZERO_FLAG_EN
  logic            z2_q, z2_d, z3_q, z3_d;
`endif

  logic [4:0] lz;
  logic       zero1;

  always_comb begin
    zero1 = zh1_q && zl1_q;
    if (!zh1_q) begin
      lz = {1'b0, lzh1_q};
    end else if (!zl1_q) begin
      lz = 5'd12 + {1'b0, lzl1_q};
    end else begin
      lz = 5'd24;
    end
  end

  always_comb begin
    x1_d   = x1_q;
    v1_d   = v1_q;
    lzh1_d = lzh1_q;
    lzl1_d = lzl1_q;
    zh1_d  = zh1_q;
    zl1_d  = zl1_q;
    x2_d   = x2_q;
    v2_d   = v2_q;
    s2_d   = s2_q;
    e2_d   = e2_q;
    xf_d   = xf_q;
    v3_d   = v3_q;
    e3_d   = e3_q;
`ifdef SQRT_RR_ZERO_FLAG_EN
    z2_d   = z2_q;
    z3_d   = z3_q;
`endif
    if (iEn) begin
      x1_d   = iX;
      v1_d   = iValid;
      lzh1_d = lzc12(iX[23:12]);
      lzl1_d = lzc12(iX[11:0]);
      zh1_d  = (iX[23:12] == 12'd0);
      zl1_d  = (iX[11:0] == 12'd0);

      x2_d   = x1_q;
      v2_d   = v1_q;
      s2_d   = {lz[4:1], 1'b0};
      e2_d   = zero1 ? 6'd0 : 6'd29 - {1'b0, lz};

      // Bits [1:0] of the shifted operand are dropped; even shift keeps [21:20] nonzero.
      xf_d   = 22'((x2_q << s2_q) >> 2);
      v3_d   = v2_q;
      e3_d   = e2_q;
`ifdef SQRT_RR_ZERO_FLAG_EN
      z2_d   = zero1;
      z3_d   = z2_q;
`endif
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      x1_q   <= '0;
      v1_q   <= 1'b0;
      lzh1_q <= '0;
      lzl1_q <= '0;
      zh1_q  <= 1'b0;
      zl1_q  <= 1'b0;
      x2_q   <= '0;
      v2_q   <= 1'b0;
      s2_q   <= '0;
      e2_q   <= '0;
      xf_q   <= '0;
      v3_q   <= 1'b0;
      e3_q   <= '0;
`ifdef SQRT_RR_ZERO_FLAG_EN
      z2_q   <= 1'b0;
      z3_q   <= 1'b0;
`endif
    end else begin
      x1_q   <= x1_d;
      v1_q   <= v1_d;
      lzh1_q <= lzh1_d;
      lzl1_q <= lzl1_d;
      zh1_q  <= zh1_d;
      zl1_q  <= zl1_d;
      x2_q   <= x2_d;
      v2_q   <= v2_d;
      s2_q   <= s2_d;
      e2_q   <= e2_d;
      xf_q   <= xf_d;
      v3_q   <= v3_d;
      e3_q   <= e3_d;
`ifdef SQRT_RR_ZERO_FLAG_EN
      z2_q   <= z2_d;
      z3_q   <= z3_d;
`endif
    end
  end

  assign oValid = v3_q;
  assign oExp_f = e3_q;
  assign oX_f   = xf_q;
`ifdef SQRT_RR_ZERO_FLAG_EN
  assign oZero  = z3_q;
`endif

endmodule

// File: tb/tb_sqrt_range_reduce.sv
// Scoreboard bench for sqrt_range_reduce: directed vectors, stall, bubble and mid-stream reset.
module tb_sqrt_range_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        valid;
  logic [23:0] x;
  logic        ovalid;
  logic [5:0]  oexp;
  logic [21:0] oxf;
`ifdef SQRT_RR_ZERO_FLAG_EN
  logic        ozero;
`endif

  sqrt_range_reduce dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iEn    (en),
    .iValid (valid),
    .iX     (x),
    .oValid (ovalid),
    .oExp_f (oexp),
    .oX_f   (oxf)
`ifdef SQRT_RR_ZERO_FLAG_EN
    ,
    .oZero  (ozero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] x;
    logic [5:0]  e;
    logic [21:0] m;
    int          stamp;
  } exp_t;

  exp_t sb[$];
  int   ecnt     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: only enabled edges advance the pipeline, so only they are checked.
  initial begin
    logic en_edge;
    exp_t t;
    forever begin
      @(posedge clk);
      en_edge = rst_n && en;
      #1;
      if (en_edge && rst_n) begin
        ecnt++;
        if (ovalid) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
          end else begin
            t = sb.pop_front();
            check("latency", ecnt, t.stamp);
            check("exp", {26'd0, oexp}, {26'd0, t.e});
            check("mant", {10'd0, oxf}, {10'd0, t.m});
`ifdef SQRT_RR_ZERO_FLAG_EN
            check("zero_flag", {31'd0, ozero}, {31'd0, (t.x == 24'd0)});
`endif
            if (t.x != 24'd0) check("mant_top_nonzero", {31'd0, (oxf[21:20] != 2'b00)}, 32'd1);
          end
        end else if (sb.size() != 0 && sb[0].stamp <= ecnt) begin
          check("missing_output", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [23:0] vx, input logic [5:0] ve, input logic [21:0] vm);
    exp_t t;
    @(negedge clk);
    en    = 1'b1;
    valid = 1'b1;
    x     = vx;
    t.x = vx; t.e = ve; t.m = vm; t.stamp = ecnt + 3;
    sb.push_back(t);
  endtask

  task automatic idle();
    @(negedge clk);
    en    = 1'b1;
    valid = 1'b0;
    x     = 24'hA5A5A5;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, {31'd0, ovalid}, 32'd0);
    check({name, "_exp"}, {26'd0, oexp}, 32'd0);
    check({name, "_mant"}, {10'd0, oxf}, 32'd0);
`ifdef SQRT_RR_ZERO_FLAG_EN
    check({name, "_zero"}, {31'd0, ozero}, 32'd0);
`endif
  endtask

  // Hand-computed vectors: operand, exponent code, mantissa.
  logic [23:0] tx [14] = '{24'h800000, 24'h000001, 24'h000003, 24'h000000, 24'hFFFFFF,
                           24'h400000, 24'h000800, 24'h001000, 24'h000FFF, 24'h123456,
                           24'h00ABCD, 24'h7FFFFF, 24'h000002, 24'h0F0000};
  logic [5:0]  te [14] = '{6'd29, 6'd6, 6'd7, 6'd0, 6'd29,
                           6'd28, 6'd17, 6'd18, 6'd17, 6'd26,
                           6'd21, 6'd28, 6'd7, 6'd25};
  logic [21:0] tm [14] = '{22'h200000, 22'h100000, 22'h300000, 22'h000000, 22'h3FFFFF,
                           22'h100000, 22'h200000, 22'h100000, 22'h3FFC00, 22'h123456,
                           22'h2AF340, 22'h1FFFFF, 22'h200000, 22'h3C0000};

  initial begin
    logic        snap_v;
    logic [5:0]  snap_e;
    logic [21:0] snap_m;
    rst_n = 1'b0;
    en    = 1'b0;
    valid = 1'b0;
    x     = 24'd0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Isolated sample followed by bubbles.
    send(24'h800000, 6'd29, 22'h200000);
    repeat (4) idle();

    for (int i = 0; i < 14; i++) send(tx[i], te[i], tm[i]);
    idle();

    // Walking one: odd bit positions land on mantissa bit 21, even ones on bit 20.
    for (int k = 0; k < 24; k++) begin
      send(24'd1 << k, 6'(6 + k), (k % 2 == 1) ? 22'h200000 : 22'h100000);
    end

    // Five-cycle stall mid-burst with junk valid input that must be ignored.
    for (int i = 0; i < 5; i++) send(tx[i + 5], te[i + 5], tm[i + 5]);
    @(negedge clk);
    en     = 1'b0;
    valid  = 1'b1;
    snap_v = ovalid;
    snap_e = oexp;
    snap_m = oxf;
    for (int i = 0; i < 5; i++) begin
      x = 24'($urandom);
      @(posedge clk);
      #2;
      check("stall_valid", {31'd0, ovalid}, {31'd0, snap_v});
      check("stall_exp", {26'd0, oexp}, {26'd0, snap_e});
      check("stall_mant", {10'd0, oxf}, {10'd0, snap_m});
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) send(tx[i + 9], te[i + 9], tm[i + 9]);
    idle();
    repeat (4) idle();

    // Reset with samples in flight: outputs clear asynchronously, old samples vanish.
    send(24'h000001, 6'd6, 22'h100000);
    send(24'h000003, 6'd7, 22'h300000);
    send(24'h000000, 6'd0, 22'h000000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(24'h00ABCD, 6'd21, 22'h2AF340);
    send(24'h000000, 6'd0, 22'h000000);
    send(24'hFFFFFF, 6'd29, 22'h3FFFFF);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
